// File: rtl/target_port.sv
// -----------------------------------------------------------------------------
// target_port
//
// Serial-to-parallel front end sitting directly upstream of the byte-memory
// target. A bus frame (rw flag, 16-bit address LSB-first, and for writes an
// 8-bit data byte LSB-first) is deserialized, filtered on the device ID held
// in address bits [15:12], and turned into a single-cycle parallel request.
// The target's ack completes the transaction. For reads, the returned byte is
// shifted back out on the bus LSB-first.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   bus_valid          frame active; one serial bit per cycle while high
//   bus_data           serial address / write-data bit, LSB-first
//   bus_rw             1 = write, 0 = read; sampled on the first frame cycle
//   bus_rdata          serial read-data bit, LSB-first
//   bus_rdata_valid    qualifies bus_rdata
//   bus_ack            one-cycle pulse: transaction complete
//   bus_err            one-cycle pulse: target timeout / read without data
//   bus_busy           high whenever the controller is not idle
//   tgt_addr           request address (full 16 bits, ID bits included)
//   tgt_addr_valid     one-cycle request strobe
//   tgt_wdata          write data (0 on reads)
//   tgt_wdata_valid    asserted together with tgt_addr_valid on writes
//   tgt_rw             request direction, stable from ISSUE through WAIT_ACK
//   tgt_rdata          target read data
//   tgt_rdata_valid    qualifies tgt_rdata
//   tgt_ack            target completion pulse
//   tgt_ready          target can accept a request
//
// Every output is a register loaded from the next-state logic, so an output
// reacts on the same edge as the state transition that produces it.
// -----------------------------------------------------------------------------
module target_port #(
  parameter logic [3:0] DEVICE_ID   = 4'h0,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_valid,
  input  logic        bus_data,
  input  logic        bus_rw,
  output logic        bus_rdata,
  output logic        bus_rdata_valid,
  output logic        bus_ack,
  output logic        bus_err,
  output logic        bus_busy,
  output logic [15:0] tgt_addr,
  output logic        tgt_addr_valid,
  output logic [7:0]  tgt_wdata,
  output logic        tgt_wdata_valid,
  output logic        tgt_rw,
  input  logic [7:0]  tgt_rdata,
  input  logic        tgt_rdata_valid,
  input  logic        tgt_ack,
  input  logic        tgt_ready
);

  localparam int                CNT_W    = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, SKIP, ISSUE, WAIT_ACK, RDATA, DONE
  } state_t;

  state_t            state, state_n;
  logic              bus_valid_q;
  logic [3:0]        bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0]  ack_cnt, ack_cnt_n;
  logic              rw, rw_n;

  // Shift registers: data only, never reset
  logic [15:0]       addr_sr;
  logic [7:0]        wdata_sr;
  logic [7:0]        rdata_sr;

  logic              addr_shift, wdata_shift, rdata_load, rdata_shift;
  logic              req_load;
  logic [15:0]       req_addr;
  logic [7:0]        req_wdata;

  logic              bus_rdata_n, bus_rdata_valid_n, bus_ack_n, bus_err_n;
  logic              tgt_addr_valid_n, tgt_wdata_valid_n;

  // Value of each shift register including the bit presented this cycle, so
  // the last serial bit can be used in the same cycle it arrives.
  logic [15:0]       frame_addr;
  logic [7:0]        frame_wdata;
  assign frame_addr  = {bus_data, addr_sr[15:1]};
  assign frame_wdata = {bus_data, wdata_sr[7:1]};

  always_comb begin
    state_n           = state;
    bit_cnt_n         = bit_cnt;
    ack_cnt_n         = ack_cnt;
    rw_n              = rw;
    addr_shift        = 1'b0;
    wdata_shift       = 1'b0;
    rdata_load        = 1'b0;
    rdata_shift       = 1'b0;
    req_load          = 1'b0;
    req_addr          = addr_sr;
    req_wdata         = 8'h00;
    bus_rdata_n       = 1'b0;
    bus_rdata_valid_n = 1'b0;
    bus_ack_n         = 1'b0;
    bus_err_n         = 1'b0;
    tgt_addr_valid_n  = 1'b0;
    tgt_wdata_valid_n = 1'b0;

    case (state)
      IDLE: begin
        // Only a rising edge starts a frame; a bus held high after the
        // previous frame must drop for at least one cycle first.
        if (bus_valid && !bus_valid_q) begin
          rw_n       = bus_rw;
          addr_shift = 1'b1;
          bit_cnt_n  = 4'd1;
          state_n    = ADDR;
        end
      end

      ADDR: begin
        if (!bus_valid) begin
          state_n = IDLE;
        end else begin
          addr_shift = 1'b1;
          if (bit_cnt == 4'd15) begin
            bit_cnt_n = 4'd0;
            if (frame_addr[15:12] != DEVICE_ID) begin
              state_n = SKIP;
            end else if (rw) begin
              state_n = WDATA;
            end else begin
              req_load = 1'b1;
              req_addr = frame_addr;
              state_n  = ISSUE;
            end
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end

      WDATA: begin
        if (!bus_valid) begin
          state_n = IDLE;
        end else begin
          wdata_shift = 1'b1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = 4'd0;
            req_load  = 1'b1;
            req_wdata = frame_wdata;
            state_n   = ISSUE;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end

      SKIP: begin
        if (!bus_valid) state_n = IDLE;
      end

      ISSUE: begin
        if (tgt_ready) begin
          tgt_addr_valid_n  = 1'b1;
          tgt_wdata_valid_n = rw;
          ack_cnt_n         = '0;
          state_n           = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (tgt_ack) begin
          if (rw) begin
            state_n = DONE;
          end else if (tgt_rdata_valid) begin
            rdata_load = 1'b1;
            bit_cnt_n  = 4'd0;
            state_n    = RDATA;
          end else begin
            // A read acked without data cannot be completed
            bus_err_n = 1'b1;
            state_n   = IDLE;
          end
        end else if (ack_cnt == CNT_LAST) begin
          bus_err_n = 1'b1;
          state_n   = IDLE;
        end else begin
          ack_cnt_n = ack_cnt + 1'b1;
        end
      end

      RDATA: begin
        bus_rdata_n       = rdata_sr[0];
        bus_rdata_valid_n = 1'b1;
        rdata_shift       = 1'b1;
        if (bit_cnt == 4'd7) begin
          bit_cnt_n = 4'd0;
          state_n   = DONE;
        end else begin
          bit_cnt_n = bit_cnt + 4'd1;
        end
      end

      DONE: begin
        bus_ack_n = 1'b1;
        state_n   = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus_valid_q     <= 1'b0;
      bit_cnt         <= 4'd0;
      ack_cnt         <= '0;
      rw              <= 1'b0;
      bus_rdata       <= 1'b0;
      bus_rdata_valid <= 1'b0;
      bus_ack         <= 1'b0;
      bus_err         <= 1'b0;
      bus_busy        <= 1'b0;
      tgt_addr        <= 16'h0000;
      tgt_addr_valid  <= 1'b0;
      tgt_wdata       <= 8'h00;
      tgt_wdata_valid <= 1'b0;
      tgt_rw          <= 1'b0;
    end else begin
      state           <= state_n;
      bus_valid_q     <= bus_valid;
      bit_cnt         <= bit_cnt_n;
      ack_cnt         <= ack_cnt_n;
      rw              <= rw_n;
      bus_rdata       <= bus_rdata_n;
      bus_rdata_valid <= bus_rdata_valid_n;
      bus_ack         <= bus_ack_n;
      bus_err         <= bus_err_n;
      bus_busy        <= (state_n != IDLE);
      tgt_addr_valid  <= tgt_addr_valid_n;
      tgt_wdata_valid <= tgt_wdata_valid_n;
      // Request fields are loaded on entry to ISSUE and then held, keeping
      // them stable while the target works on the request.
      if (req_load) begin
        tgt_addr  <= req_addr;
        tgt_wdata <= req_wdata;
        tgt_rw    <= rw;
      end
    end
  end

  // Shift registers
  always_ff @(posedge clk) begin
    if (addr_shift)  addr_sr  <= frame_addr;
    if (wdata_shift) wdata_sr <= frame_wdata;
    if (rdata_load)
      rdata_sr <= tgt_rdata;
    else if (rdata_shift)
      rdata_sr <= {1'b0, rdata_sr[7:1]};
  end

endmodule

// File: tb/tb_target_port.sv
// -----------------------------------------------------------------------------
// tb_target_port
//
// Bench for target_port. A stimulus process drives bus frames, a target model
// acts as a byte memory behind the DUT, and a monitor compares every request,
// read-data byte and completion against expectations queued when each frame
// was issued. Expectations come from a byte-memory reference model.
// -----------------------------------------------------------------------------
module tb_target_port;

  localparam logic [3:0] DEV = 4'h0;
  localparam int         TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_valid = 1'b0;
  logic        bus_data = 1'b0;
  logic        bus_rw = 1'b0;
  logic        bus_rdata, bus_rdata_valid, bus_ack, bus_err, bus_busy;
  logic [15:0] tgt_addr;
  logic        tgt_addr_valid;
  logic [7:0]  tgt_wdata;
  logic        tgt_wdata_valid, tgt_rw;
  logic [7:0]  tgt_rdata = 8'h00;
  logic        tgt_rdata_valid = 1'b0;
  logic        tgt_ack = 1'b0;
  logic        tgt_ready = 1'b1;

  target_port #(.DEVICE_ID(DEV), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_valid(bus_valid), .bus_data(bus_data), .bus_rw(bus_rw),
    .bus_rdata(bus_rdata), .bus_rdata_valid(bus_rdata_valid),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_busy(bus_busy),
    .tgt_addr(tgt_addr), .tgt_addr_valid(tgt_addr_valid),
    .tgt_wdata(tgt_wdata), .tgt_wdata_valid(tgt_wdata_valid), .tgt_rw(tgt_rw),
    .tgt_rdata(tgt_rdata), .tgt_rdata_valid(tgt_rdata_valid),
    .tgt_ack(tgt_ack), .tgt_ready(tgt_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] outs;
  assign outs = {bus_rdata, bus_rdata_valid, bus_ack, bus_err, bus_busy,
                 tgt_addr, tgt_addr_valid, tgt_wdata, tgt_wdata_valid, tgt_rw};

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues
  typedef struct { bit rw; logic [15:0] addr; logic [7:0] wdata; } req_t;
  typedef struct { bit is_err; bit rw; logic [7:0] rdata; } resp_t;
  req_t  exp_req[$];
  resp_t exp_resp[$];

  // Target-side memory and the bench's independent reference memory
  logic [7:0] tgt_mem [int];
  logic [7:0] ref_mem [int];

  // Target behaviour knobs (written by the stimulus process only)
  int ack_mode   = 0;     // 0 normal, 1 never ack, 2 ack without rdata_valid
  int ack_delay  = 0;
  int hold_len   = 0;
  int hold_start = -100;
  bit ready_rand = 1'b0;
  bit stray_ok   = 1'b0;
  int last_bit_cyc = 0;

  // Target model: reacts just after each rising edge
  int          cd = -1;
  logic        p_rw = 1'b0;
  logic [15:0] p_addr = 16'h0;
  always begin
    @(posedge clk);
    #1;
    tgt_ack         = 1'b0;
    tgt_rdata_valid = 1'b0;
    tgt_rdata       = 8'($urandom);
    if (!rst_n) begin
      cd = -1;
    end else begin
      if (tgt_addr_valid) begin
        p_rw   = tgt_rw;
        p_addr = tgt_addr;
        if (tgt_wdata_valid) tgt_mem[int'(tgt_addr)] = tgt_wdata;
        cd = (ack_mode == 1) ? -1 : ack_delay;
      end
      if (cd == 0) begin
        tgt_ack = 1'b1;
        if (!p_rw && ack_mode != 2) begin
          tgt_rdata_valid = 1'b1;
          tgt_rdata = tgt_mem.exists(int'(p_addr)) ? tgt_mem[int'(p_addr)] : 8'h00;
        end
        cd = -1;
      end else if (cd > 0) begin
        cd--;
      end else if (stray_ok && $urandom_range(0, 3) == 0) begin
        tgt_ack = 1'b1;
      end
    end
    if (hold_len > 0 && cyc >= hold_start && cyc < hold_start + hold_len)
      tgt_ready = 1'b0;
    else if (ready_rand)
      tgt_ready = ($urandom_range(0, 2) != 0);
    else
      tgt_ready = 1'b1;
  end

  // Monitor
  logic [7:0] rbyte = 8'h00;
  int rbits = 0;
  int n_req = 0;
  int ev_req_cyc = 0, ev_ack_cyc = 0, ev_err_cyc = 0, ev_rbit0_cyc = 0;
  req_t  m_req;
  resp_t m_resp;
  always @(negedge clk) begin
    if (!rst_n) begin
      rbits = 0;
    end else begin
      if (tgt_addr_valid) begin
        n_req++;
        ev_req_cyc = cyc;
        if (exp_req.size() == 0) begin
          check("unexpected_req", 32'(tgt_addr_valid), 32'd0);
        end else begin
          m_req = exp_req.pop_front();
          check("req_addr",   32'(tgt_addr),        32'(m_req.addr));
          check("req_wdata",  32'(tgt_wdata),       32'(m_req.wdata));
          check("req_wvalid", 32'(tgt_wdata_valid), 32'(m_req.rw));
          check("req_rw",     32'(tgt_rw),          32'(m_req.rw));
        end
      end else if (tgt_wdata_valid) begin
        check("wvalid_alone", 32'(tgt_wdata_valid), 32'd0);
      end
      if (bus_rdata_valid) begin
        if (rbits == 0) ev_rbit0_cyc = cyc;
        if (rbits < 8) rbyte[rbits[2:0]] = bus_rdata;
        rbits++;
      end
      if (bus_ack || bus_err) begin
        if (bus_ack) ev_ack_cyc = cyc;
        else         ev_err_cyc = cyc;
        if (exp_resp.size() == 0) begin
          check("unexpected_done", 32'({bus_ack, bus_err}), 32'd0);
        end else begin
          m_resp = exp_resp.pop_front();
          check("done_kind", 32'({bus_ack, bus_err}), m_resp.is_err ? 32'd1 : 32'd2);
          check("done_busy", 32'(bus_busy), 32'd0);
          if (!m_resp.is_err && !m_resp.rw) begin
            check("rd_bits", 32'(rbits), 32'd8);
            check("rd_byte", 32'(rbyte), 32'(m_resp.rdata));
          end else begin
            check("rd_bits", 32'(rbits), 32'd0);
          end
        end
        rbits = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus_busy) check("idle_timeout", 32'(bus_busy), 32'd0);
    @(negedge clk);
  endtask

  // Drive one frame; abort_at >= 0 drops bus_valid after that many bits.
  task automatic send_frame(input bit rw, input logic [15:0] a, input logic [7:0] d,
                            input int abort_at, input int extra_hi);
    int          nb;
    bit          aborted;
    logic [23:0] bits;
    req_t        r;
    resp_t       s;
    nb      = rw ? 24 : 16;
    aborted = (abort_at >= 0 && abort_at < nb);
    bits    = {d, a};
    if (!aborted && a[15:12] == DEV) begin
      r.rw = rw; r.addr = a; r.wdata = rw ? d : 8'h00;
      exp_req.push_back(r);
      s.rw     = rw;
      s.is_err = (ack_mode == 1) || (!rw && ack_mode == 2);
      s.rdata  = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
      exp_resp.push_back(s);
      if (rw) ref_mem[int'(a)] = d;
    end
    for (int i = 0; i < nb; i++) begin
      if (aborted && i == abort_at) break;
      @(negedge clk);
      bus_valid = 1'b1;
      bus_rw    = (i == 0) ? rw : 1'($urandom);
      bus_data  = bits[i];
      stray_ok  = (i != nb - 1);
      if (i == nb - 1) begin
        last_bit_cyc = cyc + 1;
        hold_start   = cyc + 1;
      end
    end
    if (!aborted) begin
      repeat (extra_hi) begin
        @(negedge clk);
        bus_data = 1'($urandom);
        bus_rw   = 1'($urandom);
      end
    end
    @(negedge clk);
    bus_valid = 1'b0;
    bus_data  = 1'($urandom);
    stray_ok  = 1'b0;
    wait_idle();
    stray_ok = 1'b1;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          nr;
    bit          rw;
    logic [15:0] a;
    logic [23:0] rbits_v;
    int          ab, nb;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outs", outs, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", outs, 32'd0);

    // Write 0xA5 to 0x0005
    send_frame(1'b1, 16'h0005, 8'hA5, -1, 0);
    check("wr_req_lat", 32'(ev_req_cyc), 32'(last_bit_cyc + 1));
    check("wr_ack_lat", 32'(ev_ack_cyc), 32'(last_bit_cyc + 3));

    // Read it back, bus held high past the frame end
    send_frame(1'b0, 16'h0005, 8'h00, -1, 2);
    check("rd_bit0_lat", 32'(ev_rbit0_cyc), 32'(last_bit_cyc + 3));
    check("rd_ack_lat",  32'(ev_ack_cyc),   32'(last_bit_cyc + 11));

    // ID mismatch is ignored; next frame serviced
    nr = n_req;
    send_frame(1'b1, 16'h3005, 8'h11, -1, 1);
    check("id_mismatch_noreq", 32'(n_req), 32'(nr));
    send_frame(1'b0, 16'h0005, 8'h00, -1, 0);

    // Abort after 10 address bits; then a complete write and read-back
    nr = n_req;
    send_frame(1'b1, 16'h0009, 8'h77, 10, 0);
    check("abort_noreq", 32'(n_req), 32'(nr));
    send_frame(1'b1, 16'h0009, 8'h77, -1, 0);
    send_frame(1'b0, 16'h0009, 8'h00, -1, 0);

    // Backpressure then timeout
    hold_len = 5;
    ack_mode = 1;
    send_frame(1'b0, 16'h0005, 8'h00, -1, 0);
    check("bp_req_lat",  32'(ev_req_cyc), 32'(last_bit_cyc + 6));
    check("tmo_err_lat", 32'(ev_err_cyc), 32'(ev_req_cyc + TMO));
    hold_len = 0;
    ack_mode = 0;

    // Reset asserted part-way through the write data
    nr = n_req;
    rbits_v = {8'h5A, 16'h0005};
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      bus_valid = 1'b1;
      bus_rw    = (i == 0);
      bus_data  = rbits_v[i];
    end
    @(negedge clk);
    check("wdata_busy", 32'(bus_busy), 32'd1);
    rst_n     = 1'b0;
    bus_valid = 1'b0;
    #1;
    check("rst_mid_outs", outs, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_noreq", 32'(n_req), 32'(nr));
    send_frame(1'b0, 16'h0005, 8'h00, -1, 0);

    // Randomized traffic
    ready_rand = 1'b1;
    for (int k = 0; k < 120; k++) begin
      rw = 1'($urandom);
      a  = {($urandom_range(0, 3) == 0) ? 4'($urandom) : DEV, 8'h0F, 4'($urandom)};
      case ($urandom_range(0, 13))
        0:       ack_mode = 1;
        1:       ack_mode = 2;
        default: ack_mode = 0;
      endcase
      ack_delay = $urandom_range(0, 3);
      nb = rw ? 24 : 16;
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, nb - 1) : -1;
      send_frame(rw, a, 8'($urandom), ab, $urandom_range(0, 3));
    end

    check("exp_req_left",  32'(exp_req.size()),  32'd0);
    check("exp_resp_left", 32'(exp_resp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
